// File: rtl/demux_unpacker_pkg.sv
// Shared definitions for the double-rate sample path (capture-side demux,
// readback unpacker, readback controller).
//   HALF_W / WORD_W : sample width and packed double-sample word width.
//   unpack_state_e  : EMPTY / FIRST / SECOND half-emission states.
//   select_half     : picks the upper or lower half of a packed word.
package demux_unpacker_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } unpack_state_e;

  function automatic logic [HALF_W-1:0] select_half(input logic [WORD_W-1:0] word,
                                                    input logic              upper);
    return upper ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/demux_unpacker_if.sv
// Valid/ready stream with a last marker.
//   valid : source has a beat        data : beat payload (DATA_W bits)
//   last  : final beat of a capture  ready : sink accepts on valid & ready
// master drives valid/data/last; slave drives ready.
interface demux_unpacker_if
  import demux_unpacker_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_W
);

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/demux_unpacker.sv
// Readback unpacker: turns stored 32-bit double-rate words {late, early}
// into a stream of 16-bit samples, one per clock. In demux mode each word
// yields two samples (early half first unless HIGH_FIRST); otherwise only
// the low half is emitted.
// Ports:
//   clock, reset_n : rising-edge clock, async active-low reset
//   clear          : synchronous flush (drops held word, zeroes counter)
//   demux_mode     : 1 = two samples per word, latched at word acceptance
//   in_if          : 32-bit word stream in (slave)
//   out_if         : 16-bit sample stream out (master)
//   sample_count   : output handshakes since reset/clear, wraps silently
module demux_unpacker
  import demux_unpacker_pkg::*;
#(
  parameter int unsigned COUNT_W    = 32,
  parameter bit          HIGH_FIRST = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               demux_mode,
  demux_unpacker_if.slave    in_if,
  demux_unpacker_if.master   out_if,
  output logic [COUNT_W-1:0] sample_count
);

  unpack_state_e     state_q;
  unpack_state_e     state_d;
  logic [WORD_W-1:0] word_q;
  logic              mode_q;
  logic              last_q;

  logic              final_half;
  logic              in_ready_w;
  logic              out_valid_w;
  logic              in_accept;
  logic              out_accept;

  // The half currently presented is the word's final one.
  assign final_half = (state_q == ST_SECOND) || ((state_q == ST_FIRST) && !mode_q);
  assign in_accept  = in_if.valid && in_ready_w;
  assign out_accept = out_valid_w && out_if.ready;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_accept) state_d = ST_FIRST;
        end
        ST_FIRST: begin
          if (out_accept) begin
            if (mode_q)         state_d = ST_SECOND;
            else if (in_accept) state_d = ST_FIRST;
            else                state_d = ST_EMPTY;
          end
        end
        ST_SECOND: begin
          if (out_accept) state_d = in_accept ? ST_FIRST : ST_EMPTY;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Output logic; in_ready looks at out_ready so a new word can load in the
  // same cycle the final half leaves, keeping the stream gap-free.
  always_comb begin
    in_ready_w   = !clear && ((state_q == ST_EMPTY) || (final_half && out_if.ready));
    out_valid_w  = (state_q != ST_EMPTY);
    out_if.data  = '0;
    out_if.last  = last_q && final_half;
    unique case (state_q)
      ST_FIRST:  out_if.data = mode_q ? select_half(word_q, HIGH_FIRST)
                                      : word_q[HALF_W-1:0];
      ST_SECOND: out_if.data = select_half(word_q, !HIGH_FIRST);
      default:   out_if.data = '0;
    endcase
  end

  assign in_if.ready  = in_ready_w;
  assign out_if.valid = out_valid_w;

  // Held word with its mode and last marker, captured together so a later
  // demux_mode change cannot alter a word already in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      mode_q <= 1'b0;
      last_q <= 1'b0;
    end else if (clear) begin
      word_q <= '0;
      mode_q <= 1'b0;
      last_q <= 1'b0;
    end else if (in_accept) begin
      word_q <= in_if.data;
      mode_q <= demux_mode;
      last_q <= in_if.last;
    end
  end

  // Output handshake counter; clear wins over a same-cycle handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_count <= '0;
    end else if (clear) begin
      sample_count <= '0;
    end else if (out_accept) begin
      sample_count <= sample_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_unpacker.sv
module tb_demux_unpacker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        demux_mode;
  logic [3:0]  count_a;
  logic [31:0] count_b;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  always #5 clock = ~clock;

  demux_unpacker_if #(.DATA_W(32)) in_a ();
  demux_unpacker_if #(.DATA_W(16)) out_a ();
  demux_unpacker_if #(.DATA_W(32)) in_b ();
  demux_unpacker_if #(.DATA_W(16)) out_b ();

  assign in_b.valid  = in_a.valid;
  assign in_b.data   = in_a.data;
  assign in_b.last   = in_a.last;
  assign out_b.ready = out_a.ready;

  demux_unpacker #(.COUNT_W(4), .HIGH_FIRST(1'b0)) dut_a (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (clear),
    .demux_mode   (demux_mode),
    .in_if        (in_a),
    .out_if       (out_a),
    .sample_count (count_a)
  );

  demux_unpacker #(.COUNT_W(32), .HIGH_FIRST(1'b1)) dut_b (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (clear),
    .demux_mode   (demux_mode),
    .in_if        (in_b),
    .out_if       (out_b),
    .sample_count (count_b)
  );

  typedef struct {
    logic        clr;
    logic        mode;
    logic        iv;
    logic [31:0] idata;
    logic        ilast;
    logic        ordy;
    logic        e_valid;
    logic [15:0] e_data_a;
    logic [15:0] e_data_b;
    logic        e_last;
    logic        e_rdy;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
  } samp_t;

  vec_t  vecs[23];
  samp_t model_q[$];
  logic [31:0] model_cnt;

  function automatic vec_t mk(logic clr, logic mode, logic iv, logic [31:0] idata,
                              logic ilast, logic ordy, logic e_valid,
                              logic [15:0] e_data_a, logic [15:0] e_data_b,
                              logic e_last, logic e_rdy, logic [31:0] e_cnt);
    vec_t v;
    v.clr = clr; v.mode = mode; v.iv = iv; v.idata = idata; v.ilast = ilast;
    v.ordy = ordy; v.e_valid = e_valid; v.e_data_a = e_data_a;
    v.e_data_b = e_data_b; v.e_last = e_last; v.e_rdy = e_rdy; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic clr, input logic mode, input logic iv,
                       input logic [31:0] idata, input logic ilast, input logic ordy);
    clear       = clr;
    demux_mode  = mode;
    in_a.valid  = iv;
    in_a.data   = idata;
    in_a.last   = ilast;
    out_a.ready = ordy;
  endtask

  task automatic check_all(input string tag, input logic e_valid, input logic [15:0] e_da,
                           input logic [15:0] e_db, input logic e_last, input logic e_rdy,
                           input logic [31:0] e_cnt);
    chk({tag, ".valid_a"}, 32'(out_a.valid), 32'(e_valid));
    chk({tag, ".data_a"},  32'(out_a.data),  32'(e_da));
    chk({tag, ".last_a"},  32'(out_a.last),  32'(e_last));
    chk({tag, ".ready_a"}, 32'(in_a.ready),  32'(e_rdy));
    chk({tag, ".count_a"}, 32'(count_a),     e_cnt & 32'hF);
    chk({tag, ".data_b"},  32'(out_b.data),  32'(e_db));
    chk({tag, ".last_b"},  32'(out_b.last),  32'(e_last));
    chk({tag, ".count_b"}, count_b,          e_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(0,1,1,32'hBBBB_AAAA,0,1, 0,16'h0000,16'h0000,0,1,0);
    vecs[1]  = mk(0,1,1,32'hDDDD_CCCC,1,1, 1,16'hAAAA,16'hBBBB,0,0,0);
    vecs[2]  = mk(0,1,1,32'hDDDD_CCCC,1,1, 1,16'hBBBB,16'hAAAA,0,1,1);
    vecs[3]  = mk(0,1,0,32'h0,0,1,         1,16'hCCCC,16'hDDDD,0,0,2);
    vecs[4]  = mk(0,1,0,32'h0,0,1,         1,16'hDDDD,16'hCCCC,1,1,3);
    vecs[5]  = mk(0,0,1,32'h1234_0001,0,1, 0,16'h0000,16'h0000,0,1,4);
    vecs[6]  = mk(0,0,1,32'h5678_0002,1,1, 1,16'h0001,16'h0001,0,1,4);
    vecs[7]  = mk(0,0,0,32'h0,0,1,         1,16'h0002,16'h0002,1,1,5);
    vecs[8]  = mk(0,1,1,32'h2222_1111,0,0, 0,16'h0000,16'h0000,0,1,6);
    for (int i = 9; i <= 13; i++)
      vecs[i] = mk(0,1,1,32'h9999_9999,0,0, 1,16'h1111,16'h2222,0,0,6);
    vecs[14] = mk(0,1,1,32'h9999_9999,0,1, 1,16'h1111,16'h2222,0,0,6);
    vecs[15] = mk(0,1,0,32'h0,0,1,         1,16'h2222,16'h1111,0,1,7);
    vecs[16] = mk(0,1,1,32'h4444_3333,0,1, 0,16'h0000,16'h0000,0,1,8);
    vecs[17] = mk(0,1,0,32'h0,0,1,         1,16'h3333,16'h4444,0,0,8);
    vecs[18] = mk(1,1,1,32'h6666_5555,0,1, 1,16'h4444,16'h3333,0,0,9);
    vecs[19] = mk(0,1,1,32'h8888_7777,1,1, 0,16'h0000,16'h0000,0,1,0);
    vecs[20] = mk(0,0,0,32'h0,0,1,         1,16'h7777,16'h8888,0,0,0);
    vecs[21] = mk(0,0,0,32'h0,0,1,         1,16'h8888,16'h7777,1,1,1);
    vecs[22] = mk(0,0,0,32'h0,0,1,         0,16'h0000,16'h0000,0,1,2);

    // Reset
    reset_n = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all("reset", 0, 16'h0, 16'h0, 0, 1, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].clr, vecs[i].mode, vecs[i].iv, vecs[i].idata, vecs[i].ilast, vecs[i].ordy);
      @(negedge clock);
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data_a, vecs[i].e_data_b,
                vecs[i].e_last, vecs[i].e_rdy, vecs[i].e_cnt);
      @(posedge clock); #1;
    end

    // Counter wrap: clear, then a continuous demux stream; 17 handshakes
    // take the 4-bit counter 15 -> 0 -> 1.
    drive(1, 1, 0, 32'h0, 0, 1);
    @(posedge clock); #1;
    for (int j = 0; j <= 18; j++) begin
      drive(0, 1, 1, 32'hF00D_0000 | 32'(j), 0, 1);
      @(negedge clock);
      chk($sformatf("wrap%0d.count_a", j), 32'(count_a), (j == 0) ? 32'd0 : 32'((j - 1) % 16));
      chk($sformatf("wrap%0d.count_b", j), count_b, (j == 0) ? 32'd0 : 32'(j - 1));
      @(posedge clock); #1;
    end

    // Asynchronous reset while in SECOND
    drive(1, 1, 0, 32'h0, 0, 1);
    @(posedge clock); #1;
    drive(0, 1, 1, 32'hABCD_1234, 0, 1);
    @(posedge clock); #1;
    drive(0, 1, 0, 32'h0, 0, 1);
    @(posedge clock); #1;
    drive(0, 1, 0, 32'h0, 0, 0);
    @(negedge clock);
    chk("pre_rst.data_a", 32'(out_a.data), 32'h0000_ABCD);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst.valid_a", 32'(out_a.valid), 32'd0);
    chk("async_rst.count_a", 32'(count_a), 32'd0);
    chk("async_rst.count_b", count_b, 32'd0);
    chk("async_rst.data_a", 32'(out_a.data), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    drive(0, 1, 0, 32'h0, 0, 1);
    @(negedge clock);
    chk("post_rst.ready_a", 32'(in_a.ready), 32'd1);
    chk("post_rst.valid_a", 32'(out_a.valid), 32'd0);
    @(posedge clock); #1;

    // Randomized run against the sample-queue model
    model_q.delete();
    model_cnt = '0;
    for (int c = 0; c < 1500; c++) begin
      logic        r_clr, r_mode, r_iv, r_last, r_ordy;
      logic [31:0] r_data;
      logic        e_valid, e_rdy, in_acc, out_acc;
      samp_t       head;
      r_clr  = ($urandom_range(99, 0) < 4);
      r_mode = 1'($urandom_range(1, 0));
      r_iv   = ($urandom_range(99, 0) < 70);
      r_data = $urandom;
      r_last = ($urandom_range(99, 0) < 25);
      r_ordy = ($urandom_range(99, 0) < 70);
      drive(r_clr, r_mode, r_iv, r_data, r_last, r_ordy);
      @(negedge clock);
      e_valid = (model_q.size() != 0);
      head    = e_valid ? model_q[0] : '{a: 16'h0, b: 16'h0, last: 1'b0};
      e_rdy   = !r_clr && ((model_q.size() == 0) || ((model_q.size() == 1) && r_ordy));
      check_all($sformatf("rnd%0d", c), e_valid, head.a, head.b, head.last, e_rdy, model_cnt);
      in_acc  = r_iv && e_rdy;
      out_acc = e_valid && r_ordy;
      @(posedge clock); #1;
      if (r_clr) begin
        model_q.delete();
        model_cnt = '0;
      end else begin
        if (out_acc) begin
          void'(model_q.pop_front());
          model_cnt = model_cnt + 1;
        end
        if (in_acc) begin
          if (r_mode) begin
            model_q.push_back('{a: r_data[15:0],  b: r_data[31:16], last: 1'b0});
            model_q.push_back('{a: r_data[31:16], b: r_data[15:0],  last: r_last});
          end else begin
            model_q.push_back('{a: r_data[15:0], b: r_data[15:0], last: r_last});
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/demux_unpacker.md
Name: demux_unpacker

Overview:
- Inverse of the capture-side demultiplexer: converts stored 32-bit double-rate sample words back into a stream of 16-bit samples, one sample per clock.
- Sits on the readback path between sample memory and the transmitter/serializer.
- Each word is {late_half[31:16], early_half[15:0]}; early half is emitted first.
- In non-demux mode only the low 16 bits of a word are meaningful, so one sample is emitted per word.

Parameters:
- COUNT_W, 32, width of emitted-sample counter; counter wraps modulo 2^COUNT_W.
- HIGH_FIRST, 0, 1 = emit [31:16] before [15:0] (debug/byte-order option); fixed at elaboration.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: drop held word, zero counter.
- demux_mode  in  1  1 = two samples per word, 0 = one sample per word; sampled per word at acceptance.
- in_valid  in  1  upstream word valid.
- in_data  in  32  packed sample word.
- in_last  in  1  word is final of capture.
- in_ready  out  1  word accepted on in_valid & in_ready.
- out_valid  out  1  sample valid.
- out_data  out  16  sample.
- out_last  out  1  final sample of capture.
- out_ready  in  1  downstream accepts on out_valid & out_ready.
- sample_count  out  COUNT_W  number of output handshakes since reset/clear.

Behaviour:
- Reset (reset_n=0, async): state=EMPTY; word register, mode bit, last bit and sample_count = 0; out_valid=0, out_data=0, out_last=0. in_ready=1 once reset deasserts.
- Internal state: one 32-bit word register, latched mode bit, latched last bit, FSM {EMPTY, FIRST, SECOND}.
- out_valid = (state != EMPTY), registered-state-derived.
- out_data: FIRST → first half per HIGH_FIRST; SECOND → other half. In FIRST with mode bit=0, always [15:0] regardless of HIGH_FIRST.
- Final half = SECOND, or FIRST with mode bit=0.
- out_last = latched last bit AND state is the final half; otherwise 0.
- in_ready (combinational) = !clear AND (state==EMPTY OR (final half AND out_ready)). Word accepted in the same cycle as the final sample leaves gives full throughput.
- Transitions:
  - EMPTY + in accept → FIRST; latch word, demux_mode, in_last.
  - FIRST + out accept: mode=1 → SECOND; mode=0 → FIRST if new word accepted, else EMPTY.
  - SECOND + out accept → FIRST if new word accepted, else EMPTY.
  - No out accept: hold state and out_data stable (AXI-style: valid never drops without a handshake).
- Latency: word accepted at cycle N → first sample valid at N+1. Sustained rate: 1 sample/cycle with demux_mode=1 and upstream always valid.
- sample_count increments by 1 on every output handshake; wraps from all-ones to 0 without a flag.
- clear=1: next state EMPTY; held word discarded; sample_count ← 0; an output handshake in the same cycle is not counted; in_ready=0. clear has priority over all events.
- demux_mode changes while a word is held do not affect that word.
- Output backpressure only through out_ready; no samples are dropped or duplicated.

Decomposition:
- Shared package: FSM state encoding (EMPTY/FIRST/SECOND) and constants HALF_W=16 and WORD_W=32, reused by the capture-side demux and by the readback controller.
- No sub-module needed. A single flat module of about 150–250 lines: FSM, word register, half-select mux, counter.

Test Plan:
- Reset mid-stream: pulse reset_n low while in SECOND → out_valid=0, sample_count=0 immediately, async; in_ready=1 after release.
- demux_mode=1, out_ready=1, words 0xBBBB_AAAA then 0xDDDD_CCCC back-to-back, last on second → out_data AAAA, BBBB, CCCC, DDDD on consecutive cycles; out_last only with DDDD; sample_count=4.
- demux_mode=0, words 0x1234_0001, 0x5678_0002 → outputs 0001, 0002 only; one sample per word; in_ready high every cycle.
- Backpressure: out_ready=0 for 5 cycles during FIRST of 0x2222_1111 → out_data holds 1111, in_ready=0; release → 1111, 2222, no loss.
- clear asserted in SECOND with out_ready=1 → state EMPTY next cycle, count=0, handshake not counted, in_ready=0 during clear.
- COUNT_W=4: 17 output handshakes → sample_count wraps 15→0→1.
